// File: rtl/serial_add_seq_pkg.sv
// Shared types and defaults for the bit-serial adder stage.
package serial_add_pkg;

  localparam int unsigned SERIAL_ADD_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder used as the datapath of the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | ((x ^ y) & ci);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: operands shifted LSB-first through one full-adder cell, carry kept in a FF.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_q, c_d;
  logic              cout_q, cout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fa_s, fa_co;
  logic [WIDTH:0]    sum_cat;
  logic              unused_sum_lsb;
`ifdef SERIAL_ADD_OVF_EN
  logic              c_msb_q, c_msb_d;
`endif

  fa_cell u_fa (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; the stale LSB falls off the end.
  assign sum_cat        = {fa_s, sum_sh_q};
  assign unused_sum_lsb = sum_cat[0];

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    sum_d     = sum_q;
    c_d       = c_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    c_msb_d   = c_msb_q;
`endif
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_cat[WIDTH:1];
        c_d      = fa_co;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // Result registers load only here so they hold through RUN of the next op.
          sum_d   = sum_cat[WIDTH:1];
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          c_msb_d = c_q;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
      c_msb_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      c_msb_q  <= c_msb_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = c_msb_q ^ cout_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: WIDTH=8 and WIDTH=2 instances against an arithmetic model.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf8, ovf2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf8)
`endif
  );

  serial_add_seq #(.WIDTH(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .cin       (cin2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .sum       (sum2),
    .cout      (cout2)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signed overflow: the true signed sum does not fit in w bits.
  function automatic logic ref_ovf(input int w, input int unsigned av, input int unsigned bv,
                                   input int unsigned cv);
    int lim, sa, sb, r;
    lim = 1 << (w - 1);
    sa  = (av >= lim) ? int'(av) - 2 * lim : int'(av);
    sb  = (bv >= lim) ? int'(bv) - 2 * lim : int'(bv);
    r   = sa + sb + int'(cv);
    return (r >= lim) || (r < -lim);
  endfunction

  // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input int bp);
    int unsigned s;
    int          lat;
    logic [8:0]  held;
    s = av + bv + cv;
    check("in_ready8 pre-accept", in_ready8, 1'b1);
    a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
    out_ready8 = (bp == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) in_valid8 = 1'b0;
    end while (!out_valid8 && lat < 40);
    check("latency8", lat, 9);
    check("result8", {cout8, sum8}, s[8:0]);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf8", ovf8, ref_ovf(8, av, bv, cv));
`endif
    held = {cout8, sum8};
    for (int i = 0; i < bp; i++) begin
      in_valid8 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
      check("bp out_valid8", out_valid8, 1'b1);
      check("bp in_ready8", in_ready8, 1'b0);
      check("bp hold8", {cout8, sum8}, held);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    check("retire in_ready8", in_ready8, 1'b1);
    check("retire out_valid8", out_valid8, 1'b0);
    check("retire hold8", {cout8, sum8}, s[8:0]);
  endtask

  task automatic op2(input logic [1:0] av, input logic [1:0] bv, input logic cv);
    int unsigned s;
    int          lat;
    s = av + bv + cv;
    check("in_ready2 pre-accept", in_ready2, 1'b1);
    a2 = av; b2 = bv; cin2 = cv; in_valid2 = 1'b1; out_ready2 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) in_valid2 = 1'b0;
    end while (!out_valid2 && lat < 20);
    check("latency2", lat, 3);
    check("result2", {cout2, sum2}, s[2:0]);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf2", ovf2, ref_ovf(2, av, bv, cv));
`endif
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready8", in_ready8, 1'b1);
    check("reset out_valid8", out_valid8, 1'b0);
    check("reset result8", {cout8, sum8}, 9'h000);
    check("reset in_ready2", in_ready2, 1'b1);
    check("reset out_valid2", out_valid2, 1'b0);

    op8(8'hFF, 8'h01, 1'b0, 0);
    op8(8'h55, 8'hAA, 1'b1, 0);
    op8(8'h12, 8'h34, 1'b0, 0);
    op8(8'h7F, 8'h01, 1'b0, 0);
    op8(8'h80, 8'h80, 1'b0, 0);
    op8(8'h9C, 8'h3E, 1'b1, 5);

    // Reset during the third RUN cycle, then a clean add must show no stale carry.
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst in_ready8", in_ready8, 1'b1);
    check("midrst out_valid8", out_valid8, 1'b0);
    check("midrst result8", {cout8, sum8}, 9'h000);
    op8(8'h03, 8'h04, 1'b0, 0);

    for (int i = 0; i < 32; i++) begin
      op2(2'(i >> 3), 2'(i >> 1), 1'(i));
    end

    for (int i = 0; i < 25; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
